// File: rtl/svc_rv_redirect_ctl.sv
// Fetch redirect controller: ranks MEM/EX/ID redirect requests, drives the PC
// mux and per-stage flushes, and holds a winning redirect while the PC stalls.
module svc_rv_redirect_ctl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             redir_mem,
    input  logic [XLEN-1:0]  target_mem,
    input  logic             redir_ex,
    input  logic [XLEN-1:0]  target_ex,
    input  logic             pred_id,
    input  logic [XLEN-1:0]  target_id,

    input  logic             pc_ready,

    output logic [1:0]       pc_sel,
    output logic [XLEN-1:0]  pc_target,
    output logic             flush_if,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             pending,

    output logic [CNT_W-1:0] cnt_mem,
    output logic [CNT_W-1:0] cnt_ex,
    output logic [CNT_W-1:0] cnt_id
);

    localparam logic [1:0] PC_SEL_SEQUENTIAL = 2'd0;
    localparam logic [1:0] PC_SEL_PREDICTED  = 2'd1;
    localparam logic [1:0] PC_SEL_REDIRECT   = 2'd2;

    localparam logic [1:0] RANK_NONE = 2'd0;
    localparam logic [1:0] RANK_ID   = 2'd1;
    localparam logic [1:0] RANK_EX   = 2'd2;
    localparam logic [1:0] RANK_MEM  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic            pend_valid_reg;
    logic [1:0]      pend_rank_reg;
    logic [XLEN-1:0] pend_target_reg;

    logic            pend_valid_next;
    logic [1:0]      pend_rank_next;
    logic [XLEN-1:0] pend_target_next;

    logic [1:0]      new_rank;
    logic [XLEN-1:0] new_target;
    logic            take_new;
    logic            pend_live;
    logic            eff_valid;
    logic [1:0]      eff_rank;
    logic [XLEN-1:0] eff_target;

    // Same-cycle arbitration: the oldest stage wins, younger requests are wrong-path.
    always_comb begin
        new_rank   = RANK_NONE;
        new_target = '0;
        if (redir_mem) begin
            new_rank   = RANK_MEM;
            new_target = target_mem;
        end else if (redir_ex) begin
            new_rank   = RANK_EX;
            new_target = target_ex;
        end else if (pred_id) begin
            new_rank   = RANK_ID;
            new_target = target_id;
        end
    end

    // A held entry is ignored while reset is asserted so the held redirect never leaks out.
    assign pend_live = pend_valid_reg && rst_n;

    // An invalid pending entry carries rank 0, so any real request beats it.
    always_comb begin
        take_new   = (new_rank != RANK_NONE) &&
                     (!pend_live || (new_rank >= pend_rank_reg));
        eff_valid  = take_new || pend_live;
        eff_rank   = RANK_NONE;
        eff_target = '0;
        if (take_new) begin
            eff_rank   = new_rank;
            eff_target = new_target;
        end else if (pend_live) begin
            eff_rank   = pend_rank_reg;
            eff_target = pend_target_reg;
        end
    end

    always_comb begin
        pc_sel    = PC_SEL_SEQUENTIAL;
        pc_target = '0;
        if (eff_valid) begin
            pc_target = eff_target;
            pc_sel    = (eff_rank == RANK_ID) ? PC_SEL_PREDICTED : PC_SEL_REDIRECT;
        end
    end

    // A replayed entry already flushed the pipe when it first won; only IF
    // needs killing again because it keeps fetching down the wrong path.
    assign flush_if = take_new || pend_live;
    assign flush_id = take_new && (new_rank >= RANK_EX);
    assign flush_ex = take_new && (new_rank == RANK_MEM);

    always_comb begin
        pend_valid_next  = 1'b0;
        pend_rank_next   = RANK_NONE;
        pend_target_next = '0;
        if (eff_valid && !pc_ready) begin
            pend_valid_next  = 1'b1;
            pend_rank_next   = eff_rank;
            pend_target_next = eff_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_valid_reg  <= 1'b0;
            pend_rank_reg   <= RANK_NONE;
            pend_target_reg <= '0;
        end else begin
            pend_valid_reg  <= pend_valid_next;
            pend_rank_reg   <= pend_rank_next;
            pend_target_reg <= pend_target_next;
        end
    end

    assign pending = pend_valid_reg;

    // Win counters indexed by rank: 1=ID, 2=EX, 3=MEM.
    logic [CNT_W-1:0] cnt_reg [1:3];

    generate
        for (genvar gi = 1; gi <= 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_next;

            always_comb begin
                cnt_next = cnt_reg[gi];
                if (take_new && (new_rank == 2'(gi))) begin
                    cnt_next = cnt_reg[gi] + CNT_ONE;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= '0;
                end else begin
                    cnt_reg[gi] <= cnt_next;
                end
            end
        end
    endgenerate

    assign cnt_id  = cnt_reg[1];
    assign cnt_ex  = cnt_reg[2];
    assign cnt_mem = cnt_reg[3];

endmodule

// File: tb/tb_svc_rv_redirect_ctl.sv
// Directed self-checking bench for svc_rv_redirect_ctl (CNT_W=4 build).
module tb_svc_rv_redirect_ctl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    localparam logic [1:0] SEL_SEQ  = 2'd0;
    localparam logic [1:0] SEL_PRED = 2'd1;
    localparam logic [1:0] SEL_REDIR = 2'd2;

    logic             clk;
    logic             rst_n;
    logic             redir_mem;
    logic [XLEN-1:0]  target_mem;
    logic             redir_ex;
    logic [XLEN-1:0]  target_ex;
    logic             pred_id;
    logic [XLEN-1:0]  target_id;
    logic             pc_ready;
    logic [1:0]       pc_sel;
    logic [XLEN-1:0]  pc_target;
    logic             flush_if;
    logic             flush_id;
    logic             flush_ex;
    logic             pending;
    logic [CNT_W-1:0] cnt_mem;
    logic [CNT_W-1:0] cnt_ex;
    logic [CNT_W-1:0] cnt_id;

    int errors = 0;
    int checks = 0;

    svc_rv_redirect_ctl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .redir_mem(redir_mem), .target_mem(target_mem),
        .redir_ex(redir_ex), .target_ex(target_ex),
        .pred_id(pred_id), .target_id(target_id),
        .pc_ready(pc_ready),
        .pc_sel(pc_sel), .pc_target(pc_target),
        .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
        .pending(pending),
        .cnt_mem(cnt_mem), .cnt_ex(cnt_ex), .cnt_id(cnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are applied 1 time unit after a rising edge; combinational
    // outputs are sampled 2 units later, well clear of either edge.
    task automatic drive(input logic m, input logic [XLEN-1:0] tm,
                         input logic e, input logic [XLEN-1:0] te,
                         input logic i, input logic [XLEN-1:0] ti,
                         input logic rdy);
        redir_mem = m;  target_mem = tm;
        redir_ex  = e;  target_ex  = te;
        pred_id   = i;  target_id  = ti;
        pc_ready  = rdy;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        do_reset();
        idle();
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %0b expected 0", pending); end
        checks++; if (pc_sel !== SEL_SEQ) begin errors++; $display("FAIL reset_pc_sel: got %0d expected %0d", pc_sel, SEL_SEQ); end
        checks++; if (pc_target !== 32'h0) begin errors++; $display("FAIL reset_pc_target: got 0x%0h expected 0x0", pc_target); end
        checks++; if (flush_if !== 1'b0) begin errors++; $display("FAIL reset_flush_if: got %0b expected 0", flush_if); end
        checks++; if ({cnt_mem, cnt_ex, cnt_id} !== 12'h0) begin errors++; $display("FAIL reset_counters: got %0h/%0h/%0h expected 0/0/0", cnt_mem, cnt_ex, cnt_id); end
        $display("test_reset done");
    endtask

    task automatic test_single_ex();
        do_reset();
        drive(1'b0, '0, 1'b1, 32'h100, 1'b0, '0, 1'b1);
        checks++; if (pc_sel !== SEL_REDIR) begin errors++; $display("FAIL ex_pc_sel: got %0d expected %0d", pc_sel, SEL_REDIR); end
        checks++; if (pc_target !== 32'h100) begin errors++; $display("FAIL ex_pc_target: got 0x%0h expected 0x100", pc_target); end
        checks++; if ({flush_if, flush_id, flush_ex} !== 3'b110) begin errors++; $display("FAIL ex_flushes: got %b expected 110", {flush_if, flush_id, flush_ex}); end
        tick();
        idle();
        checks++; if (cnt_ex !== 4'd1) begin errors++; $display("FAIL ex_cnt: got %0d expected 1", cnt_ex); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL ex_pending: got %0b expected 0", pending); end
        $display("test_single_ex done");
    endtask

    task automatic test_priority();
        do_reset();
        drive(1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h400, 1'b1);
        checks++; if (pc_sel !== SEL_REDIR) begin errors++; $display("FAIL prio_pc_sel: got %0d expected %0d", pc_sel, SEL_REDIR); end
        checks++; if (pc_target !== 32'h200) begin errors++; $display("FAIL prio_pc_target: got 0x%0h expected 0x200", pc_target); end
        checks++; if ({flush_if, flush_id, flush_ex} !== 3'b111) begin errors++; $display("FAIL prio_flushes: got %b expected 111", {flush_if, flush_id, flush_ex}); end
        tick();
        idle();
        checks++; if ({cnt_mem, cnt_ex, cnt_id} !== {4'd1, 4'd0, 4'd0}) begin errors++; $display("FAIL prio_counters: got %0d/%0d/%0d expected 1/0/0", cnt_mem, cnt_ex, cnt_id); end
        $display("test_priority done");
    endtask

    task automatic test_id_predict();
        do_reset();
        drive(1'b0, '0, 1'b0, '0, 1'b1, 32'h440, 1'b1);
        checks++; if (pc_sel !== SEL_PRED) begin errors++; $display("FAIL id_pc_sel: got %0d expected %0d", pc_sel, SEL_PRED); end
        checks++; if (pc_target !== 32'h440) begin errors++; $display("FAIL id_pc_target: got 0x%0h expected 0x440", pc_target); end
        checks++; if ({flush_if, flush_id, flush_ex} !== 3'b100) begin errors++; $display("FAIL id_flushes: got %b expected 100", {flush_if, flush_id, flush_ex}); end
        tick();
        idle();
        checks++; if (cnt_id !== 4'd1) begin errors++; $display("FAIL id_cnt: got %0d expected 1", cnt_id); end
        $display("test_id_predict done");
    endtask

    task automatic test_stall();
        do_reset();
        // Cycle 1: request arrives while PC is stalled.
        drive(1'b0, '0, 1'b1, 32'h500, 1'b0, '0, 1'b0);
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL stall_c1_pending: got %0b expected 0", pending); end
        tick();
        // Cycles 2-4: held entry replays; PC accepts on cycle 4.
        for (int c = 2; c <= 4; c++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b0, '0, (c == 4));
            checks++; if (pending !== 1'b1) begin errors++; $display("FAIL stall_c%0d_pending: got %0b expected 1", c, pending); end
            checks++; if (pc_sel !== SEL_REDIR || pc_target !== 32'h500) begin errors++; $display("FAIL stall_c%0d_pc: got sel=%0d tgt=0x%0h expected sel=%0d tgt=0x500", c, pc_sel, pc_target, SEL_REDIR); end
            checks++; if ({flush_if, flush_id, flush_ex} !== 3'b100) begin errors++; $display("FAIL stall_c%0d_flushes: got %b expected 100", c, {flush_if, flush_id, flush_ex}); end
            tick();
        end
        idle();
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL stall_clear_pending: got %0b expected 0", pending); end
        checks++; if (pc_sel !== SEL_SEQ) begin errors++; $display("FAIL stall_clear_pc_sel: got %0d expected %0d", pc_sel, SEL_SEQ); end
        checks++; if (cnt_ex !== 4'd1) begin errors++; $display("FAIL stall_cnt_ex: got %0d expected 1", cnt_ex); end
        $display("test_stall done");
    endtask

    task automatic test_replace();
        do_reset();
        drive(1'b0, '0, 1'b1, 32'h500, 1'b0, '0, 1'b0);
        tick();
        // Lower-rank ID request during the stall is dropped.
        drive(1'b0, '0, 1'b0, '0, 1'b1, 32'h600, 1'b0);
        chk("replace_id_target", pc_target, 32'h500);
        chk("replace_id_flush_id", {31'd0, flush_id}, 32'd0);
        tick();
        chk("replace_id_cnt", {28'd0, cnt_id}, 32'd0);
        // Higher-rank MEM request replaces the held EX entry.
        drive(1'b1, 32'h700, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("replace_mem_target", pc_target, 32'h700);
        chk("replace_mem_flushes", {29'd0, flush_if, flush_id, flush_ex}, 32'd7);
        tick();
        chk("replace_mem_cnt", {28'd0, cnt_mem}, 32'd1);
        chk("replace_mem_pending", {31'd0, pending}, 32'd1);
        // Equal-rank request replaces too and counts.
        drive(1'b1, 32'h880, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("replace_eq_target", pc_target, 32'h880);
        tick();
        chk("replace_eq_cnt", {28'd0, cnt_mem}, 32'd2);
        // Pending drives outputs in the accepting cycle, then clears.
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
        chk("replace_replay_target", pc_target, 32'h880);
        chk("replace_replay_flushes", {29'd0, flush_if, flush_id, flush_ex}, 32'd4);
        tick();
        chk("replace_final_pending", {31'd0, pending}, 32'd0);
        chk("replace_final_cnt_ex", {28'd0, cnt_ex}, 32'd1);
        $display("test_replace done");
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1'b1, 32'h900, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rststall_pre_pending: got %0b expected 1", pending); end
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        tick();
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rststall_pending: got %0b expected 0", pending); end
        checks++; if (pc_sel !== SEL_SEQ || pc_target !== 32'h0) begin errors++; $display("FAIL rststall_pc: got sel=%0d tgt=0x%0h expected sel=0 tgt=0x0", pc_sel, pc_target); end
        checks++; if ({cnt_mem, cnt_ex, cnt_id} !== 12'h0) begin errors++; $display("FAIL rststall_counters: got %0d/%0d/%0d expected 0/0/0", cnt_mem, cnt_ex, cnt_id); end
        $display("test_reset_mid_stall done");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b0, '0, 1'b1, 32'(32'h1000 + k * 4), 1'b0, '0, 1'b1);
            checks++; if (pc_target !== 32'(32'h1000 + k * 4)) begin errors++; $display("FAIL b2b_%0d_target: got 0x%0h expected 0x%0h", k, pc_target, 32'h1000 + k * 4); end
            tick();
        end
        idle();
        checks++; if (cnt_ex !== 4'd3) begin errors++; $display("FAIL b2b_cnt_ex: got %0d expected 3", cnt_ex); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL b2b_pending: got %0b expected 0", pending); end
        $display("test_back_to_back done");
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, '0, 1'b0, '0, 1'b1, 32'h20, 1'b1);
            tick();
            if (k == 15) begin
                checks++; if (cnt_id !== 4'd15) begin errors++; $display("FAIL wrap_cnt15: got %0d expected 15", cnt_id); end
            end
        end
        idle();
        checks++; if (cnt_id !== 4'd0) begin errors++; $display("FAIL wrap_cnt0: got %0d expected 0", cnt_id); end
        $display("test_wrap done");
    endtask

    initial begin
        rst_n = 1'b0;
        redir_mem = 1'b0; target_mem = '0;
        redir_ex  = 1'b0; target_ex  = '0;
        pred_id   = 1'b0; target_id  = '0;
        pc_ready  = 1'b1;
        tick();
        test_reset();
        test_single_ex();
        test_priority();
        test_id_predict();
        test_stall();
        test_replace();
        test_reset_mid_stall();
        test_back_to_back();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/svc_rv_redirect_ctl.md
# svc_rv_redirect_ctl

Sequential redirect controller for the RV fetch front end. Arbitrates redirect and prediction requests from MEM (JALR misprediction), EX (branch/jump resolution) and ID (static prediction), generates per-stage flushes, and holds a winning redirect while the PC register is stalled so no request is lost. Drives the PC mux select and target, and keeps per-source redirect counters for performance analysis.

## Interface

Parameters:
- XLEN, 32, address width
- CNT_W, 32, width of each redirect counter

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- redir_mem  in  1  MEM-stage JALR misprediction request
- target_mem  in  XLEN  MEM redirect target
- redir_ex  in  1  EX-stage redirect request
- target_ex  in  XLEN  EX redirect target
- pred_id  in  1  ID-stage static prediction request
- target_id  in  XLEN  ID predicted target
- pc_ready  in  1  PC register accepts a new PC this cycle
- pc_sel  out  2  PC_SEL_SEQUENTIAL / PC_SEL_PREDICTED / PC_SEL_REDIRECT (svc_rv_defs.svh encoding)
- pc_target  out  XLEN  target for non-sequential selection; 0 when sequential
- flush_if  out  1  kill IF-stage instruction
- flush_id  out  1  kill ID-stage instruction
- flush_ex  out  1  kill EX-stage instruction
- pending  out  1  registered redirect awaiting pc_ready
- cnt_mem, cnt_ex, cnt_id  out  CNT_W each  wrapping win counters per source

## Operation

- Source rank: MEM=3 > EX=2 > ID=1. Same-cycle requests: highest rank wins; lower-rank requests dropped (younger, wrong path).
- Pending register holds {valid, rank, target}. Effective winner each cycle: new winner if rank ≥ pending rank, else pending entry. New request of lower rank than pending is dropped.
- Output mapping of effective winner: rank 3 or 2 -> pc_sel=PC_SEL_REDIRECT; rank 1 -> PC_SEL_PREDICTED; none -> PC_SEL_SEQUENTIAL, pc_target=0.
- Flushes (combinational, only for a new winning request, not for a replayed pending entry): MEM -> flush_if, flush_id, flush_ex; EX -> flush_if, flush_id; ID -> flush_if. flush_if also asserted every cycle pending=1 (IF holds wrong-path fetch).
- Capture: if effective winner exists and pc_ready=0, register it into pending (valid=1). If pc_ready=1, pending cleared (winner consumed).
- Counters: increment source counter in every cycle a new request of that source wins (replayed pending never counts). Wrap at 2^CNT_W.
- Reset (rst_n=0 at clk edge): pending valid=0, rank=0, target=0, all counters 0. Combinational outputs follow inputs with pending cleared; reset mid-stall discards the held redirect.

## Timing

- Zero-cycle latency: pc_sel/pc_target/flushes valid in the same cycle as the request.
- Held redirect appears on outputs from the cycle after capture until the cycle pc_ready=1 (inclusive); pending=1 during that span.
- Replacement of a pending entry by an equal/higher-rank request takes effect combinationally that cycle and is registered if still stalled.
- Simultaneous pending + pc_ready=1 + no new request: pending drives outputs, then clears next edge.
- No internal wait states; block never back-pressures sources.

## Test plan

- Single EX redirect, target 0x100, pc_ready=1 -> pc_sel=REDIRECT, pc_target=0x100, flush_if=flush_id=1, flush_ex=0, cnt_ex=1, pending stays 0.
- MEM 0x200, EX 0x300, ID 0x400 same cycle -> target 0x200, all three flushes, only cnt_mem increments.
- EX 0x500 with pc_ready=0 for 3 cycles -> pending=1 for cycles 2–4 with pc_sel=REDIRECT, target 0x500, flush_if=1, flush_id=0; cleared after pc_ready=1; cnt_ex=1.
- Pending EX 0x500; ID 0x600 during stall -> dropped, target stays 0x500, cnt_id unchanged; then MEM 0x700 -> replaces, target 0x700, all flushes, cnt_mem=1.
- Stall with pending MEM, assert rst_n=0 one cycle -> pending=0, counters 0, pc_sel=SEQUENTIAL, pc_target=0.
- Preload: drive 2^CNT_W ID wins (CNT_W=4 build: 16) -> cnt_id wraps to 0.
